// File: rtl/checksum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checksum_pkg
// Description : Definitions shared by the transmit and receive ends of the
//               checksummed byte link: default check key, frame length and
//               the transmit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package checksum_pkg;

    // Check key shared with the receive-side checker.
    localparam logic [7:0] DEFAULT_KEY = 8'h37;

    // start + 8 data + 8 check + stop
    localparam int FRAME_BITS = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/checksum_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : checksum_bit_timer
// Description : Divides the clock down to one tick per serial bit. Counts
//               0..CLKS_PER_BIT-1 while enabled, ticks on the terminal count
//               and wraps. Held at 0 while disabled, so every frame starts
//               from a fresh count.
// Revision    : 1.0 - initial release
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               en   - count enable (a frame is in progress)
//               tick - high for the last cycle of each bit time
// ============================================================================
module checksum_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    // A 1-cycle bit still needs a 1-bit counter to keep the logic well formed.
    localparam int              c_CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [c_CW-1:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/checksum_tx.sv
`default_nettype none
// ============================================================================
// Module      : checksum_tx
// Description : Transmit end of the checksummed byte link. Accepts one byte
//               per valid/ready handshake and serialises an 18-bit frame
//               (start 0, data LSB first, check = data ^ KEY LSB first,
//               stop 1) onto an idle-high line, CLKS_PER_BIT cycles per bit.
// Revision    : 1.0 - initial release
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               data_in   - byte to send, sampled on the accepting edge
//               valid_in  - data_in is valid
//               ready_out - block can accept a byte (IDLE)
//               tx        - registered serial line, idles high
//               busy      - frame in progress
//               done      - one-cycle pulse after the stop bit
// ============================================================================
module checksum_tx
    import checksum_pkg::*;
#(
    parameter logic [7:0] KEY          = DEFAULT_KEY,
    parameter int         CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [7:0] r_data_sr;
    logic [7:0] r_chk_sr;
    logic [2:0] r_bit_cnt;
    logic       r_tx;
    logic       r_done;
    logic       w_tick;
    logic       w_accept;
    logic       w_last_bit;

    assign ready_out  = (r_state == IDLE);
    assign busy       = ~ready_out;
    assign tx         = r_tx;
    assign done       = r_done;
    assign w_accept   = valid_in & ready_out;
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // The timer is disabled in IDLE, which holds it at 0 so the start bit
    // always gets a full bit time after the accepting edge.
    checksum_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)                 w_state_next = START;
            START:   if (w_tick)                   w_state_next = DATA;
            DATA:    if (w_tick && w_last_bit)     w_state_next = CHECK;
            CHECK:   if (w_tick && w_last_bit)     w_state_next = STOP;
            STOP:    if (w_tick)                   w_state_next = IDLE;
            default:                               w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: tx is loaded on the same edge that enters each bit, so the
    // line changes together with the state. The shift registers always
    // present the next bit to send at position 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_sr <= '0;
            r_chk_sr  <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data_sr <= data_in;
                        r_chk_sr  <= data_in ^ KEY;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_data_sr[0];
                        r_data_sr <= {1'b0, r_data_sr[7:1]};
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (w_last_bit) begin
                            r_tx      <= r_chk_sr[0];
                            r_chk_sr  <= {1'b0, r_chk_sr[7:1]};
                            r_bit_cnt <= '0;
                        end else begin
                            r_tx      <= r_data_sr[0];
                            r_data_sr <= {1'b0, r_data_sr[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    if (w_tick) begin
                        if (w_last_bit) begin
                            r_tx      <= 1'b1;
                            r_bit_cnt <= '0;
                        end else begin
                            r_tx      <= r_chk_sr[0];
                            r_chk_sr  <= {1'b0, r_chk_sr[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_tx   <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_checksum_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_checksum_tx
// Description : Self-checking bench for checksum_tx. Two instances: N=4 (a)
//               and N=1 (b). A mid-bit sampling monitor per instance
//               deserialises each frame and compares it with the scoreboard
//               entry pushed when the byte was driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checksum_tx;

    localparam logic [7:0] c_KEY = 8'h37;
    localparam int         c_NA  = 4;
    localparam int         c_NB  = 1;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard entries: {data, expected check byte}
    logic [15:0] sb_a[$];
    logic [15:0] sb_b[$];

    // monitor state, index 0 = instance a, 1 = instance b
    bit          m_act[2];
    int          m_cnt[2];
    logic [17:0] m_bits[2];

    checksum_tx #(.KEY(c_KEY), .CLKS_PER_BIT(c_NA)) u_dut_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    checksum_tx #(.KEY(c_KEY), .CLKS_PER_BIT(c_NB)) u_dut_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Receive-side checker model.
    function automatic logic rx_ok(input logic [7:0] d, input logic [7:0] c);
        return (c == (d ^ c_KEY));
    endfunction

    task automatic frame_done(input int id, input logic [17:0] bits);
        logic [15:0] e;
        if (id == 0) begin
            if (sb_a.size() == 0) begin check("sb_unexpected_a", 1, 0); return; end
            e = sb_a.pop_front();
        end else begin
            if (sb_b.size() == 0) begin check("sb_unexpected_b", 1, 0); return; end
            e = sb_b.pop_front();
        end
        check("mon_start", bits[0], 1'b0);
        check("mon_data",  bits[8:1], e[15:8]);
        check("mon_check", bits[16:9], e[7:0]);
        check("mon_stop",  bits[17], 1'b1);
        check("loop_ok",   rx_ok(bits[8:1], bits[16:9]), 1'b1);
        check("loop_bad",  rx_ok(bits[8:1], bits[16:9] ^ 8'h01), 1'b0);
    endtask

    task automatic mon_step(input int id, input logic t, input logic b, input logic r, input int n);
        if (r) begin
            m_act[id] = 1'b0;
        end else begin
            if (!m_act[id] && b && !t) begin
                m_act[id] = 1'b1;
                m_cnt[id] = 0;
            end
            if (m_act[id]) begin
                if ((m_cnt[id] % n) == (n / 2)) m_bits[id][m_cnt[id] / n] = t;
                m_cnt[id]++;
                if (m_cnt[id] == 18 * n) begin
                    m_act[id] = 1'b0;
                    frame_done(id, m_bits[id]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx_a, busy_a, rst_a, c_NA);
        mon_step(1, tx_b, busy_b, rst_b, c_NB);
    end

    // Send one byte on instance a and check tx cycle by cycle. poke: cycle at
    // which a 0x55 valid pulse is injected; rst_at: cycle at which reset is
    // asserted. Zero disables either.
    task automatic send_a(input logic [7:0] d, input logic [7:0] c, input int poke, input int rst_at);
        logic [17:0] fr;
        int t;
        t = 0;
        while (!ready_a && t < 200) begin @(negedge clk); t++; end
        if (!ready_a) check("ready_timeout_a", 0, 1);
        fr = {1'b1, c, d, 1'b0};
        @(negedge clk);
        data_a = d; valid_a = 1'b1;
        sb_a.push_back({d, c});
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        data_a  = ~d;
        for (int k = 1; k <= 18 * c_NA + 2; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst_a = 1'b1;
                #1;
                check("rst_tx",    tx_a, 1'b1);
                check("rst_ready", ready_a, 1'b1);
                check("rst_busy",  busy_a, 1'b0);
                check("rst_done",  done_a, 1'b0);
                void'(sb_a.pop_back());
                @(negedge clk);
                rst_a = 1'b0;
                return;
            end
            if (k <= 18 * c_NA) check("tx_a", tx_a, fr[(k - 1) / c_NA]);
            if (k == 1) begin
                check("busy_first", busy_a, 1'b1);
                check("ready_first", ready_a, 1'b0);
            end
            check("done_a", done_a, (k == 18 * c_NA + 1));
            if (k == 18 * c_NA + 1) begin
                check("ready_done", ready_a, 1'b1);
                check("busy_done",  busy_a, 1'b0);
                check("tx_done",    tx_a, 1'b1);
            end
            if (k == poke) begin
                valid_a = 1'b1; data_a = 8'h55;
            end else if (k == poke + 1) begin
                valid_a = 1'b0;
            end
        end
    endtask

    initial begin
        logic [17:0] fr1;
        logic [17:0] fr2;
        logic        exp_tx;
        rst_a = 1'b1; rst_b = 1'b1;
        data_a = '0;  data_b = '0;
        valid_a = 1'b0; valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_a",    tx_a, 1'b1);
        check("reset_ready_a", ready_a, 1'b1);
        check("reset_busy_a",  busy_a, 1'b0);
        check("reset_done_a",  done_a, 1'b0);
        check("reset_tx_b",    tx_b, 1'b1);
        check("reset_ready_b", ready_b, 1'b1);
        check("reset_busy_b",  busy_b, 1'b0);
        check("reset_done_b",  done_b, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Single frames and loopback bytes
        send_a(8'hAA, 8'h9D, 0, 0);
        send_a(8'hAD, 8'h9A, 0, 0);
        send_a(8'hAF, 8'h98, 0, 0);

        // valid pulse during DATA must be ignored
        send_a(8'hAA, 8'h9D, 5 * c_NA, 0);
        repeat (30) @(negedge clk);
        check("no_second_frame", busy_a, 1'b0);

        // reset in CHECK, then a clean frame
        send_a(8'hAA, 8'h9D, 0, 12 * c_NA);
        send_a(8'h3C, 8'h0B, 0, 0);

        // N=1 corner: 18-cycle frame, done at cycle 19
        fr1 = {1'b1, 8'h9D, 8'hAA, 1'b0};
        @(negedge clk);
        data_b = 8'hAA; valid_b = 1'b1;
        sb_b.push_back({8'hAA, 8'h9D});
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("tx_b1", tx_b, (k <= 18) ? fr1[k - 1] : 1'b1);
            check("done_b1", done_b, (k == 19));
        end

        // Back-to-back with valid held high
        fr1 = {1'b1, 8'h37, 8'h00, 1'b0};
        fr2 = {1'b1, 8'hC8, 8'hFF, 1'b0};
        @(negedge clk);
        data_b = 8'h00; valid_b = 1'b1;
        sb_b.push_back({8'h00, 8'h37});
        sb_b.push_back({8'hFF, 8'hC8});
        @(posedge clk);
        #1;
        data_b = 8'hFF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 18)                exp_tx = fr1[k - 1];
            else if (k >= 20 && k <= 37) exp_tx = fr2[k - 20];
            else                         exp_tx = 1'b1;
            check("tx_b2b", tx_b, exp_tx);
            check("done_b2b", done_b, (k == 19) || (k == 38));
            if (k == 20) valid_b = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("sb_left_a", sb_a.size(), 0);
        check("sb_left_b", sb_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
